// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction memory loader and the instruction memory model:
// FSM state encoding and the byte-lane ordering of a 32-bit word.
package imem_loader_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE      = 2'd0;
    localparam logic [STATE_W-1:0] ST_WAIT_WORD = 2'd1;
    localparam logic [STATE_W-1:0] ST_WRITE     = 2'd2;
    localparam logic [STATE_W-1:0] ST_DONE      = 2'd3;

    // Byte index 0 of a word carries bits [31:24] (big-endian).
    localparam bit LANE_MSB_FIRST = 1'b1;

    function automatic logic [7:0] word_lane(input logic [31:0] word, input logic [1:0] idx);
        logic [1:0] lane;
        lane = LANE_MSB_FIRST ? (2'd3 - idx) : idx;
        return word[{lane, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Control, word-stream and byte-write bus of the instruction memory loader.
// The loader uses the slave modport; the session controller and source use master.
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CNT_W  = 7
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  word_count;
    logic              in_valid;
    logic [31:0]       in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              busy;
    logic              done;

    modport master (
        output start, abort, base_addr, word_count, in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, busy, done
    );

    modport slave (
        input  start, abort, base_addr, word_count, in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, busy, done
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: accepts 32-bit words on a valid/ready port and stores each
// one as four consecutive byte writes, most significant byte first.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CNT_W  = 7
) (
    input logic          clk,
    input logic          rst_n,
    imem_loader_if.slave bus
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [1:0]         idx_q, idx_d;
    logic [31:0]        word_q, word_d;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        idx_d       = idx_q;
        word_d      = word_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    ptr_d       = bus.base_addr;
                    remaining_d = bus.word_count;
                    idx_d       = 2'd0;
                    state_d     = (bus.word_count != '0) ? ST_WAIT_WORD : ST_DONE;
                end
            end
            ST_WAIT_WORD: begin
                if (bus.in_valid) begin
                    word_d  = bus.in_data;
                    idx_d   = 2'd0;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // Pointer wraps naturally at 2^ADDR_W.
                ptr_d = ptr_q + 1'b1;
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    remaining_d = remaining_q - 1'b1;
                    state_d     = (remaining_q == CNT_W'(1)) ? ST_DONE : ST_WAIT_WORD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides every transition, including a start seen in IDLE.
        if (bus.abort) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            idx_q       <= 2'd0;
            word_q      <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            idx_q       <= idx_d;
            word_q      <= word_d;
        end
    end

    // Outputs come only from registered state, so in_ready never depends on in_valid.
    assign bus.in_ready  = (state_q == ST_WAIT_WORD);
    assign bus.mem_we    = (state_q == ST_WRITE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.mem_addr  = ptr_q;
    assign bus.mem_wdata = word_lane(word_q, idx_q);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte-write log, done/busy/handshake logs and a byte-wide
// instruction memory model read back as words.
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int overlap = 0;
    int start_cyc = 0;
    int wb, db, bb, ab, ob;

    int         w_cyc[$];
    logic [7:0] w_addr[$];
    logic [7:0] w_data[$];
    int         done_cyc[$];
    int         busy_cyc[$];
    int         acc_cyc[$];

    logic [31:0] words [0:3];
    logic [7:0]  imem  [0:255];

    imem_loader_if #(.ADDR_W(8), .CNT_W(7)) bus ();

    imem_loader #(.ADDR_W(8), .CNT_W(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (bus.mem_we) imem[bus.mem_addr] <= bus.mem_wdata;

    always @(negedge clk) begin
        if (bus.mem_we) begin
            w_cyc.push_back(cyc);
            w_addr.push_back(bus.mem_addr);
            w_data.push_back(bus.mem_wdata);
        end
        if (bus.done) done_cyc.push_back(cyc);
        if (bus.busy) busy_cyc.push_back(cyc);
        if (bus.in_valid && bus.in_ready) acc_cyc.push_back(cyc);
        if (bus.mem_we && bus.in_ready) overlap++;
    end

    function automatic logic [31:0] read_word(input logic [7:0] a);
        logic [31:0] r;
        logic [7:0]  ad;
        logic [1:0]  lane;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            ad   = a + 8'(i);
            lane = LANE_MSB_FIRST ? 2'(3 - i) : 2'(i);
            r[{lane, 3'b000} +: 8] = imem[ad];
        end
        return r;
    endfunction

    task automatic mark();
        wb = w_addr.size();
        db = done_cyc.size();
        bb = busy_cyc.size();
        ab = acc_cyc.size();
        ob = overlap;
    endtask

    task automatic do_start(input logic [7:0] base, input logic [6:0] cnt);
        bus.base_addr  = base;
        bus.word_count = cnt;
        bus.start      = 1'b1;
        start_cyc      = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Presents words[0..n-1] back to back; returns just after the last acceptance edge.
    task automatic feed(input int n);
        for (int i = 0; i < n; i++) begin
            int t;
            t = 0;
            bus.in_data  = words[i];
            bus.in_valid = 1'b1;
            @(negedge clk);
            while (!bus.in_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            checks++;
            if (!bus.in_ready) begin
                errors++;
                $display("FAIL feed_timeout word %0d: in_ready=%b want 1", i, bus.in_ready);
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b want 0", bus.mem_we); end
        checks++; if (bus.mem_addr !== 8'h00) begin errors++; $display("FAIL rst_mem_addr: got %h want 00", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 8'h00) begin errors++; $display("FAIL rst_mem_wdata: got %h want 00", bus.mem_wdata); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", bus.done); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_word();
        logic [7:0] ea [0:3];
        logic [7:0] ed [0:3];
        ea = '{8'h00, 8'h01, 8'h02, 8'h03};
        ed = '{8'h8C, 8'h22, 8'h00, 8'h04};
        mark();
        words[0] = 32'h8C220004;
        do_start(8'h00, 7'd1);
        feed(1);
        repeat (8) @(negedge clk);
        checks++; if (w_addr.size() - wb !== 4) begin errors++; $display("FAIL single_nwr: got %0d want 4", w_addr.size() - wb); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (w_addr[wb+i] !== ea[i]) begin errors++; $display("FAIL single_addr[%0d]: got %h want %h", i, w_addr[wb+i], ea[i]); end
            checks++; if (w_data[wb+i] !== ed[i]) begin errors++; $display("FAIL single_data[%0d]: got %h want %h", i, w_data[wb+i], ed[i]); end
        end
        checks++; if (w_cyc[wb+3] - w_cyc[wb] !== 3) begin errors++; $display("FAIL single_span: got %0d want 3", w_cyc[wb+3] - w_cyc[wb]); end
        checks++; if (done_cyc.size() - db !== 1) begin errors++; $display("FAIL single_ndone: got %0d want 1", done_cyc.size() - db); end
        checks++; if (done_cyc[db] !== w_cyc[wb+3] + 1) begin errors++; $display("FAIL single_done_cyc: got %0d want %0d", done_cyc[db], w_cyc[wb+3] + 1); end
        checks++; if (read_word(8'h00) !== 32'h8C220004) begin errors++; $display("FAIL single_readback: got %h want 8c220004", read_word(8'h00)); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b want 0", bus.busy); end
    endtask

    task automatic test_wrap();
        logic [7:0] ea [0:3];
        logic [7:0] ed [0:3];
        ea = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        ed = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        mark();
        words[0] = 32'hAABBCCDD;
        do_start(8'hFE, 7'd1);
        feed(1);
        repeat (8) @(negedge clk);
        checks++; if (w_addr.size() - wb !== 4) begin errors++; $display("FAIL wrap_nwr: got %0d want 4", w_addr.size() - wb); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (w_addr[wb+i] !== ea[i]) begin errors++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, w_addr[wb+i], ea[i]); end
            checks++; if (w_data[wb+i] !== ed[i]) begin errors++; $display("FAIL wrap_data[%0d]: got %h want %h", i, w_data[wb+i], ed[i]); end
        end
        checks++; if (read_word(8'hFE) !== 32'hAABBCCDD) begin errors++; $display("FAIL wrap_readback: got %h want aabbccdd", read_word(8'hFE)); end
        checks++; if (done_cyc.size() - db !== 1) begin errors++; $display("FAIL wrap_ndone: got %0d want 1", done_cyc.size() - db); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d;
        mark();
        words[0] = 32'h11111111;
        words[1] = 32'h22222222;
        words[2] = 32'h33333333;
        do_start(8'h10, 7'd3);
        feed(3);
        repeat (8) @(negedge clk);
        checks++; if (w_addr.size() - wb !== 12) begin errors++; $display("FAIL b2b_nwr: got %0d want 12", w_addr.size() - wb); end
        for (int i = 0; i < 12; i++) begin
            exp_d = 8'((i / 4 + 1) * 17);
            checks++; if (w_addr[wb+i] !== 8'(8'h10 + i)) begin errors++; $display("FAIL b2b_addr[%0d]: got %h want %h", i, w_addr[wb+i], 8'(8'h10 + i)); end
            checks++; if (w_data[wb+i] !== exp_d) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, w_data[wb+i], exp_d); end
        end
        checks++; if (acc_cyc.size() - ab !== 3) begin errors++; $display("FAIL b2b_nacc: got %0d want 3", acc_cyc.size() - ab); end
        checks++; if (acc_cyc[ab+1] - acc_cyc[ab] !== 5) begin errors++; $display("FAIL b2b_acc_gap: got %0d want 5", acc_cyc[ab+1] - acc_cyc[ab]); end
        checks++; if (done_cyc[db] - acc_cyc[ab] !== 15) begin errors++; $display("FAIL b2b_done_lat: got %0d want 15", done_cyc[db] - acc_cyc[ab]); end
        checks++; if (overlap - ob !== 0) begin errors++; $display("FAIL b2b_ready_in_write: got %0d want 0", overlap - ob); end
        checks++; if (read_word(8'h18) !== 32'h33333333) begin errors++; $display("FAIL b2b_readback: got %h want 33333333", read_word(8'h18)); end
    endtask

    task automatic test_zero_count();
        @(negedge clk);
        mark();
        do_start(8'h40, 7'd0);
        repeat (6) @(negedge clk);
        checks++; if (w_addr.size() - wb !== 0) begin errors++; $display("FAIL zero_nwr: got %0d want 0", w_addr.size() - wb); end
        checks++; if (done_cyc.size() - db !== 1) begin errors++; $display("FAIL zero_ndone: got %0d want 1", done_cyc.size() - db); end
        checks++; if (done_cyc[db] !== start_cyc + 1) begin errors++; $display("FAIL zero_done_cyc: got %0d want %0d", done_cyc[db], start_cyc + 1); end
        checks++; if (busy_cyc.size() - bb !== 1) begin errors++; $display("FAIL zero_nbusy: got %0d want 1", busy_cyc.size() - bb); end
        checks++; if (busy_cyc[bb] !== start_cyc + 1) begin errors++; $display("FAIL zero_busy_cyc: got %0d want %0d", busy_cyc[bb], start_cyc + 1); end
    endtask

    task automatic test_start_ignored();
        mark();
        words[0] = 32'hC0C1C2C3;
        do_start(8'h60, 7'd1);
        feed(1);
        @(posedge clk); #1;
        bus.base_addr  = 8'h00;
        bus.word_count = 7'd5;
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        checks++; if (w_addr.size() - wb !== 4) begin errors++; $display("FAIL ign_nwr: got %0d want 4", w_addr.size() - wb); end
        checks++; if (w_addr[wb+3] !== 8'h63) begin errors++; $display("FAIL ign_last_addr: got %h want 63", w_addr[wb+3]); end
        checks++; if (w_data[wb+2] !== 8'hC2) begin errors++; $display("FAIL ign_data2: got %h want c2", w_data[wb+2]); end
        checks++; if (done_cyc.size() - db !== 1) begin errors++; $display("FAIL ign_ndone: got %0d want 1", done_cyc.size() - db); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ign_busy_end: got %b want 0", bus.busy); end
    endtask

    task automatic test_abort();
        mark();
        words[0] = 32'hA0A1A2A3;
        do_start(8'h20, 7'd4);
        feed(1);
        words[0] = 32'hB0B1B2B3;
        feed(1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
        bus.in_data  = 32'hDEADBEEF;
        bus.in_valid = 1'b1;
        repeat (6) @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if (w_addr.size() - wb !== 7) begin errors++; $display("FAIL abort_nwr: got %0d want 7", w_addr.size() - wb); end
        checks++; if (w_addr[wb+6] !== 8'h26) begin errors++; $display("FAIL abort_last_addr: got %h want 26", w_addr[wb+6]); end
        checks++; if (w_data[wb+6] !== 8'hB2) begin errors++; $display("FAIL abort_last_data: got %h want b2", w_data[wb+6]); end
        checks++; if (done_cyc.size() - db !== 0) begin errors++; $display("FAIL abort_ndone: got %0d want 0", done_cyc.size() - db); end
        checks++; if (acc_cyc.size() - ab !== 2) begin errors++; $display("FAIL abort_nacc: got %0d want 2", acc_cyc.size() - ab); end
        mark();
        words[0] = 32'h01020304;
        do_start(8'h50, 7'd1);
        feed(1);
        repeat (8) @(negedge clk);
        checks++; if (w_addr.size() - wb !== 4) begin errors++; $display("FAIL reab_nwr: got %0d want 4", w_addr.size() - wb); end
        checks++; if (read_word(8'h50) !== 32'h01020304) begin errors++; $display("FAIL reab_readback: got %h want 01020304", read_word(8'h50)); end
        checks++; if (done_cyc.size() - db !== 1) begin errors++; $display("FAIL reab_ndone: got %0d want 1", done_cyc.size() - db); end
    endtask

    task automatic test_abort_start_idle();
        @(negedge clk);
        mark();
        bus.base_addr  = 8'h00;
        bus.word_count = 7'd1;
        bus.start      = 1'b1;
        bus.abort      = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abst_busy: got %b want 0", bus.busy); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL abst_in_ready: got %b want 0", bus.in_ready); end
        repeat (4) @(negedge clk);
        checks++; if (done_cyc.size() - db !== 0) begin errors++; $display("FAIL abst_ndone: got %0d want 0", done_cyc.size() - db); end
    endtask

    task automatic test_reset_mid_write();
        words[0] = 32'h5A5A5A5A;
        do_start(8'h70, 7'd2);
        feed(1);
        @(posedge clk); #1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL mrst_mem_we: got %b want 0", bus.mem_we); end
        checks++; if (bus.mem_addr !== 8'h00) begin errors++; $display("FAIL mrst_mem_addr: got %h want 00", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 8'h00) begin errors++; $display("FAIL mrst_mem_wdata: got %h want 00", bus.mem_wdata); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mrst_busy: got %b want 0", bus.busy); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mrst_in_ready: got %b want 0", bus.in_ready); end
        @(negedge clk);
        mark();
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (done_cyc.size() - db !== 0) begin errors++; $display("FAIL mrst_ndone: got %0d want 0", done_cyc.size() - db); end
        checks++; if (w_addr.size() - wb !== 0) begin errors++; $display("FAIL mrst_nwr: got %0d want 0", w_addr.size() - wb); end
        mark();
        words[0] = 32'h8C220004;
        do_start(8'h80, 7'd1);
        feed(1);
        repeat (8) @(negedge clk);
        checks++; if (w_addr.size() - wb !== 4) begin errors++; $display("FAIL post_nwr: got %0d want 4", w_addr.size() - wb); end
        checks++; if (w_data[wb] !== 8'h8C) begin errors++; $display("FAIL post_data0: got %h want 8c", w_data[wb]); end
        checks++; if (read_word(8'h80) !== 32'h8C220004) begin errors++; $display("FAIL post_readback: got %h want 8c220004", read_word(8'h80)); end
        checks++; if (done_cyc.size() - db !== 1) begin errors++; $display("FAIL post_ndone: got %0d want 1", done_cyc.size() - db); end
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.base_addr  = 8'h00;
        bus.word_count = 7'd0;
        bus.in_valid   = 1'b0;
        bus.in_data    = 32'h0;
        test_reset();
        test_single_word();
        test_wrap();
        test_back_to_back();
        test_zero_count();
        test_start_ignored();
        test_abort();
        test_abort_start_idle();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
